// File: rtl/ir_cmd_pkg.sv
// Shared encodings for the IR command decoder: NEC key codes, one-hot motor
// commands, status-byte layout and the key/status/command mapping helpers.
package ir_cmd_pkg;

    localparam logic [7:0] KEY_FWD   = 8'h02;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_BRAKE = 8'h05;
    localparam logic [7:0] KEY_RIGHT = 8'h06;
    localparam logic [7:0] KEY_BACK  = 8'h08;

    localparam logic [7:0] CMD_STOP  = 8'h00;
    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h08;
    localparam logic [7:0] CMD_BRAKE = 8'h10;
    localparam logic [7:0] CMD_RIGHT = 8'h20;
    localparam logic [7:0] CMD_BACK  = 8'h80;

    typedef enum logic [2:0] {
        STAT_STOP  = 3'b000,
        STAT_FWD   = 3'b001,
        STAT_LEFT  = 3'b010,
        STAT_BRAKE = 3'b011,
        STAT_RIGHT = 3'b100,
        STAT_BACK  = 3'b101
    } motor_stat_t;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_TIMEOUT = 2'b10
    } fsm_t;

    typedef struct packed {
        motor_stat_t stat;
        logic [3:0]  seq;
        logic        to_flag;
    } status_t;

    function automatic motor_stat_t key_to_stat(input logic [7:0] key);
        case (key)
            KEY_FWD:   return STAT_FWD;
            KEY_LEFT:  return STAT_LEFT;
            KEY_BRAKE: return STAT_BRAKE;
            KEY_RIGHT: return STAT_RIGHT;
            KEY_BACK:  return STAT_BACK;
            default:   return STAT_STOP;
        endcase
    endfunction

    function automatic logic [7:0] stat_to_cmd(input motor_stat_t stat);
        case (stat)
            STAT_FWD:   return CMD_FWD;
            STAT_LEFT:  return CMD_LEFT;
            STAT_BRAKE: return CMD_BRAKE;
            STAT_RIGHT: return CMD_RIGHT;
            STAT_BACK:  return CMD_BACK;
            default:    return CMD_STOP;
        endcase
    endfunction

endpackage

// File: rtl/ir_status_buffer.sv
// Status byte stream stage: one output register plus a 1-deep pending slot.
// Output is held while stalled; the newest status always replaces the slot.
module ir_status_buffer
    import ir_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  status_t    status_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i
);

    status_t out_q;
    status_t pend_q;
    logic    out_vld_q;
    logic    pend_vld_q;
    logic    hs;

    assign hs         = out_vld_q && tx_ready_i;
    assign tx_data_o  = out_q;
    assign tx_valid_o = out_vld_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q      <= '0;
            pend_q     <= '0;
            out_vld_q  <= 1'b0;
            pend_vld_q <= 1'b0;
        end else if (!out_vld_q || hs) begin
            // A fresh status bypasses the slot; any older pending byte is stale.
            if (push_i) begin
                out_q      <= status_i;
                out_vld_q  <= 1'b1;
                pend_vld_q <= 1'b0;
            end else if (!out_vld_q && pend_vld_q) begin
                out_q      <= pend_q;
                out_vld_q  <= 1'b1;
                pend_vld_q <= 1'b0;
            end else begin
                out_vld_q  <= 1'b0;
            end
        end else if (push_i) begin
            pend_q     <= status_i;
            pend_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ir_cmd_decoder.sv
// NEC frame edge-detect, validation, motor FSM with dead-man timeout, status stream.
// Define IR_ADDR_FILTER_EN to also require the address byte to match IR_ADDR.
module ir_cmd_decoder
    import ir_cmd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_MS = 250,
    parameter logic [7:0]  IR_ADDR    = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_ready,
    input  logic [31:0] ir_data,
    output logic [7:0]  motor_cmd,
    output logic        bad_frame,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam longint unsigned TIMER_CYCLES = 64'(TIMEOUT_MS) * 64'(CLK_HZ) / 64'd1000;
    localparam int unsigned     TW           = $clog2(TIMER_CYCLES + 64'd1);
    localparam logic [TW-1:0]   TIMER_LOAD   = TW'(TIMER_CYCLES);

    logic          dr_q;
    logic          ev_q;
    logic [31:0]   frame_q;
    logic          dec_vld_q;
    logic          dec_ok_q;
    motor_stat_t   dec_stat_q;
    fsm_t          state_q;
    logic [7:0]    motor_cmd_q;
    logic          bad_frame_q;
    logic [TW-1:0] timer_q;
    logic [3:0]    seq_q;
    logic          push_q;
    status_t       status_q;

    logic          key_ok;
    logic          addr_ok;
    logic [3:0]    seq_d;
    logic [7:0]    cmd_d;

    assign key_ok = (frame_q[31:24] == ~frame_q[23:16]);

`ifdef IR_ADDR_FILTER_EN
    assign addr_ok = (frame_q[7:0] == IR_ADDR) && (frame_q[15:8] == ~IR_ADDR);
`else
    // Address bytes carry no meaning in this build.
    logic unused_addr;
    assign unused_addr = ^{frame_q[15:0], IR_ADDR};
    assign addr_ok     = 1'b1;
`endif

    assign seq_d = seq_q + 4'd1;
    assign cmd_d = stat_to_cmd(dec_stat_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dr_q       <= 1'b0;
            ev_q       <= 1'b0;
            frame_q    <= '0;
            dec_vld_q  <= 1'b0;
            dec_ok_q   <= 1'b0;
            dec_stat_q <= STAT_STOP;
        end else begin
            dr_q       <= data_ready;
            ev_q       <= data_ready && !dr_q;
            if (data_ready && !dr_q) begin
                frame_q <= ir_data;
            end
            dec_vld_q  <= ev_q;
            dec_ok_q   <= key_ok && addr_ok;
            dec_stat_q <= key_to_stat(frame_q[23:16]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_STOPPED;
            motor_cmd_q <= CMD_STOP;
            bad_frame_q <= 1'b0;
            timer_q     <= '0;
            seq_q       <= '0;
            push_q      <= 1'b0;
            status_q    <= '0;
        end else begin
            bad_frame_q <= 1'b0;
            push_q      <= 1'b0;
            if (dec_vld_q && !dec_ok_q) begin
                bad_frame_q <= 1'b1;
            end else if (dec_vld_q) begin
                // Checked ahead of expiry so a frame on the expiry cycle keeps us ACTIVE.
                seq_q       <= seq_d;
                timer_q     <= TIMER_LOAD;
                motor_cmd_q <= cmd_d;
                state_q     <= (dec_stat_q == STAT_STOP) ? ST_STOPPED : ST_ACTIVE;
                if (cmd_d != motor_cmd_q) begin
                    push_q   <= 1'b1;
                    status_q <= '{stat: dec_stat_q, seq: seq_d, to_flag: 1'b0};
                end
            end else if (state_q == ST_ACTIVE) begin
                if (timer_q == '0) begin
                    state_q     <= ST_TIMEOUT;
                    motor_cmd_q <= CMD_STOP;
                    push_q      <= 1'b1;
                    status_q    <= '{stat: STAT_STOP, seq: seq_q, to_flag: 1'b1};
                end else begin
                    timer_q <= timer_q - TW'(1);
                end
            end
        end
    end

    assign motor_cmd = motor_cmd_q;
    assign bad_frame = bad_frame_q;

    ir_status_buffer u_status_buffer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .push_i     (push_q),
        .status_i   (status_q),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready)
    );

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Bench for ir_cmd_decoder: frame-level reference model plus directed NEC frames.
// Timer scaled to 20 cycles (CLK_HZ=20000, TIMEOUT_MS=1) so stalls fit inside it.
module tb_ir_cmd_decoder;

    localparam int N = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_ready = 1'b0;
    logic [31:0] ir_data = '0;
    logic        tx_ready = 1'b0;
    logic [7:0]  motor_cmd;
    logic        bad_frame;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ir_cmd_decoder #(.CLK_HZ(20_000), .TIMEOUT_MS(1), .IR_ADDR(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_ready (data_ready),
        .ir_data    (ir_data),
        .motor_cmd  (motor_cmd),
        .bad_frame  (bad_frame),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    // Reference model state
    logic [7:0] m_cmd = '0;
    logic       m_bad = 1'b0;
    int         m_state = 0;   // 0 stopped, 1 active, 2 timed out
    int         m_seq = 0;
    int         m_since = 0;
    bit         m_live = 1'b0;
    bit         stall_mode = 1'b0;
    logic [7:0] exp_q[$];
    int         hs_count = 0;
    logic [7:0] last_hs = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] key_cmd(input logic [7:0] k);
        case (k)
            8'h02:   return 8'h02;
            8'h04:   return 8'h08;
            8'h05:   return 8'h10;
            8'h06:   return 8'h20;
            8'h08:   return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [2:0] cmd_stat(input logic [7:0] c);
        case (c)
            8'h02:   return 3'd1;
            8'h08:   return 3'd2;
            8'h10:   return 3'd3;
            8'h20:   return 3'd4;
            8'h80:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // While the consumer is stalled only the held byte and the newest status survive.
    task automatic push_exp(input logic [7:0] b);
        if (stall_mode && exp_q.size() >= 2) exp_q[exp_q.size()-1] = b;
        else exp_q.push_back(b);
    endtask

    initial begin : model
        logic        dr_prev;
        logic        s1v, s2v, ok;
        logic [31:0] s1d, s2d;
        logic [7:0]  nc;
        dr_prev = 1'b0; s1v = 1'b0; s2v = 1'b0; s1d = '0; s2d = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cmd = '0; m_bad = 1'b0; m_state = 0; m_seq = 0; m_since = 0;
                dr_prev = 1'b0; s1v = 1'b0; s2v = 1'b0;
                exp_q.delete();
                m_live = 1'b1;
            end else begin
                m_bad = 1'b0;
                if (s2v) begin
                    ok = (s2d[31:24] == ~s2d[23:16]);
`ifdef IR_ADDR_FILTER_EN
                    ok = ok && (s2d[7:0] == 8'h00) && (s2d[15:8] == 8'hFF);
`endif
                    if (!ok) begin
                        m_bad = 1'b1;
                    end else begin
                        nc = key_cmd(s2d[23:16]);
                        m_seq = (m_seq + 1) % 16;
                        m_since = 0;
                        if (nc != m_cmd) push_exp({cmd_stat(nc), 4'(m_seq), 1'b0});
                        m_cmd = nc;
                        m_state = (nc != 8'h00) ? 1 : 0;
                    end
                end else if (m_state == 1) begin
                    m_since++;
                    if (m_since == N + 1) begin
                        m_state = 2;
                        m_cmd = 8'h00;
                        push_exp({3'b000, 4'(m_seq), 1'b1});
                    end
                end
                s2v = s1v; s2d = s1d;
                s1v = data_ready && !dr_prev; s1d = ir_data;
                dr_prev = data_ready;
            end
        end
    end

    initial begin : compare
        bit         pv_stall;
        logic [7:0] pv_data;
        pv_stall = 1'b0; pv_data = '0;
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("motor_cmd", 32'(motor_cmd), 32'(m_cmd));
                check("bad_frame", 32'(bad_frame), 32'(m_bad));
                if (rst_n && pv_stall) begin
                    check("tx_valid_hold", 32'(tx_valid), 32'd1);
                    check("tx_data_hold", 32'(tx_data), 32'(pv_data));
                end
                if (rst_n && tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_byte_unexpected actual=%0h required=none", tx_data);
                    end else begin
                        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                    hs_count++;
                    last_hs = tx_data;
                end
                pv_stall = rst_n && tx_valid && !tx_ready;
                pv_data = tx_data;
            end
        end
    end

    // Returns one ns after the event edge.
    task automatic send_frame(input logic [31:0] d);
        @(posedge clk); #1;
        ir_data = d;
        data_ready = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
    endtask

    task automatic wait_hs(input int prev, input string nm);
        int n;
        n = 0;
        while (hs_count == prev && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (hs_count == prev) begin
            checks++; failures++;
            $display("FAIL %s actual=no_byte required=byte_within_200_cycles", nm);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int h;
        step(3);
        check("rst_motor_cmd", 32'(motor_cmd), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_bad_frame", 32'(bad_frame), 32'd0);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        step(2);

        // Forward, two-cycle latency, status byte 0x22
        h = hs_count;
        send_frame(32'hFD02_FF00);
        step(1); check("t1_lat_1clk", 32'(motor_cmd), 32'h00);
        step(1); check("t1_lat_2clk", 32'(motor_cmd), 32'h02);
        wait_hs(h, "t1_status");
        check("t1_status", 32'(last_hs), 32'h22);

        // Bad inverse: pulse only
        h = hs_count;
        send_frame(32'hFC02_FF00);
        step(1); check("t2_bad_pre", 32'(bad_frame), 32'd0);
        step(1); check("t2_bad_pulse", 32'(bad_frame), 32'd1);
        check("t2_cmd_kept", 32'(motor_cmd), 32'h02);
        step(1); check("t2_bad_end", 32'(bad_frame), 32'd0);
        check("t2_no_status", 32'(hs_count), 32'(h));

        // Dead-man timeout
        wait_hs(h, "t3_timeout");
        check("t3_status", 32'(last_hs), 32'h03);
        check("t3_cmd_stop", 32'(motor_cmd), 32'h00);

        // Stalled stream: left held, right overwritten by back
        step(4);
        tx_ready = 1'b0; stall_mode = 1'b1;
        h = hs_count;
        send_frame(32'hFB04_FF00); step(8);
        send_frame(32'hF906_FF00); step(8);
        send_frame(32'hF708_FF00); step(5);
        check("t4_held_valid", 32'(tx_valid), 32'd1);
        check("t4_held_byte", 32'(tx_data), 32'h44);
        check("t4_no_hs", 32'(hs_count), 32'(h));
        tx_ready = 1'b1; stall_mode = 1'b0;
        wait_hs(h, "t4_first");
        check("t4_first", 32'(last_hs), 32'h44);
        wait_hs(h + 1, "t4_second");
        check("t4_second", 32'(last_hs), 32'hA8);
        wait_hs(h + 2, "t4_timeout");
        check("t4_timeout", 32'(last_hs), 32'h09);

        // Level held high is one event
        h = hs_count;
        @(posedge clk); #1;
        ir_data = 32'hFD02_FF00; data_ready = 1'b1;
        step(20);
        data_ready = 1'b0;
        wait_hs(h, "t5_level");
        check("t5_level_byte", 32'(last_hs), 32'h2A);
        check("t5_level_once", 32'(hs_count), 32'(h + 1));
        wait_hs(h + 1, "t5_level_to");
        check("t5_level_to", 32'(last_hs), 32'h0B);

        // Frame on the expiry cycle keeps ACTIVE
        h = hs_count;
        send_frame(32'hFD02_FF00);
        repeat (19) @(posedge clk);
        send_frame(32'hFD02_FF00);
        step(5);
        check("t5_race_cmd", 32'(motor_cmd), 32'h02);
        check("t5_race_bytes", 32'(hs_count), 32'(h + 1));
        check("t5_race_byte", 32'(last_hs), 32'h2C);
        wait_hs(h + 1, "t5_race_to");
        check("t5_race_to", 32'(last_hs), 32'h0F);

        // Brake, unmapped valid key, repeat key
        h = hs_count;
        send_frame(32'hFA05_FF00);
        send_frame(32'hBA45_FF00);
        send_frame(32'hFA05_FF00);
        send_frame(32'hFA05_FF00);
        step(6);
        check("t7_bytes", 32'(hs_count), 32'(h + 3));
        check("t7_last", 32'(last_hs), 32'h74);
        wait_hs(h + 3, "t7_timeout");
        check("t7_timeout", 32'(last_hs), 32'h17);

        // Address byte handling
        send_frame(32'hFD02_FE01);
        step(2);
`ifdef IR_ADDR_FILTER_EN
        check("t6_addr_bad", 32'(bad_frame), 32'd1);
        check("t6_addr_cmd", 32'(motor_cmd), 32'h00);
`else
        check("t6_addr_ignored", 32'(motor_cmd), 32'h02);
`endif
        send_frame(32'hFD02_FF00);
        step(2);
        check("t6_addr_ok", 32'(motor_cmd), 32'h02);
        step(4);

        // Reset while stalled drops everything
        tx_ready = 1'b0; stall_mode = 1'b1;
        send_frame(32'hFB04_FF00);
        step(4);
        check("t6_stall_valid", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        step(1);
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_cmd", 32'(motor_cmd), 32'h00);
        rst_n = 1'b1; stall_mode = 1'b0; tx_ready = 1'b1;
        h = hs_count;
        send_frame(32'hFD02_FF00);
        wait_hs(h, "t6_after_rst");
        check("t6_after_rst", 32'(last_hs), 32'h22);
        wait_hs(h + 1, "t6_after_rst_to");
        check("t6_after_rst_to", 32'(last_hs), 32'h03);
        step(5);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
